mul_share_arb: RTL and testbench

Round-robin arbiter and issue controller that shares one pipelined SIZE x SIZE unsigned multiplier among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. Each requester's ID travels through a tag pipeline matched to the multiplier latency, so each product returns to the requester that issued it. The block sits between client engines and the multiplier instance, and drives the multiplier's enable/operand inputs directly.

---
 rtl/mul_share_arb.sv | 95 +++++++++
 tb/tb_mul_share_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ clients.
// Ports: clk, rst_n (async, active-low), arb_en, req_valid/req_a/req_b,
//        req_ready, mul_en_in/mul_a/mul_b to the multiplier,
//        mul_en_out/mul_out from it, rsp_valid/rsp_data, busy, err.
module mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 8,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    mul_en_in,
    output logic [SIZE-1:0]         mul_a,
    output logic [SIZE-1:0]         mul_b,
    input  logic                    mul_en_out,
    input  logic [2*SIZE-1:0]       mul_out,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2*SIZE-1:0]       rsp_data,
    output logic                    busy,
    output logic                    err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 runs alongside the issue register; the multiplier samples one
    // edge later, so the last stage lines up with mul_en_out.
    localparam int NT = LATENCY + 2;

    logic [IW-1:0]         ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         gid;
    logic                  gv;
    int unsigned           idx;
    logic [NT-1:0]         tag_v;
    logic [NT-1:0][IW-1:0] tag_id;

    // First valid requester after ptr, wrapping.
    always_comb begin
        grant = '0;
        gid   = '0;
        gv    = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gv && arb_en && rst_n && req_valid[idx]) begin
                gv         = 1'b1;
                gid        = IW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign busy      = mul_en_in | (|tag_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= IW'(NUM_REQ - 1);
            mul_en_in <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            mul_en_in <= gv;
            tag_v     <= {tag_v[NT-2:0], gv};
            tag_id    <= {tag_id[NT-2:0], gid};
            if (gv) begin
                ptr   <= gid;
                mul_a <= req_a[int'(gid)*SIZE +: SIZE];
                mul_b <= req_b[int'(gid)*SIZE +: SIZE];
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end
            if (mul_en_out && tag_v[NT-1]) begin
                rsp_valid <= NUM_REQ'(1) << tag_id[NT-1];
                rsp_data  <= mul_out;
            end else begin
                rsp_valid <= '0;
            end
            // Result without a tag, or a tag without a result.
            if (mul_en_out != tag_v[NT-1])
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb with a behavioural multiplier
// and a queue-based reference model of grants and returns.
module tb_mul_share_arb;

    localparam int N   = 4;
    localparam int SZ  = 8;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arb_en = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*SZ-1:0]   req_a = '0;
    logic [N*SZ-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic              mul_en_in;
    logic [SZ-1:0]     mul_a, mul_b;
    logic              mul_en_out;
    logic [2*SZ-1:0]   mul_out;
    logic [N-1:0]      rsp_valid;
    logic [2*SZ-1:0]   rsp_data;
    logic              busy, err;
    logic              spur = 1'b0;

    always #5 clk = ~clk;

    mul_share_arb #(.NUM_REQ(N), .SIZE(SZ), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_en_in(mul_en_in),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en_out(mul_en_out),
        .mul_out(mul_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err)
    );

    // Multiplier: result appears LAT cycles after it samples mul_en_in.
    logic [LAT:0]          pe;
    logic [LAT:0][2*SZ-1:0] pp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe <= '0;
            pp <= '0;
        end else begin
            pe <= {pe[LAT-1:0], mul_en_in};
            pp <= {pp[LAT-1:0], 16'(mul_a) * 16'(mul_b)};
        end
    end
    assign mul_en_out = pe[LAT] | spur;
    assign mul_out    = pp[LAT];

    typedef struct {
        int          id;
        logic [15:0] p;
        int          due;
    } op_t;

    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    int          m_ptr = N - 1;
    op_t         q[$];
    int          grants[$];
    logic [N-1:0] rv = '0;
    logic [7:0]  ra[N];
    logic [7:0]  rb[N];
    logic [15:0] m_data = '0;
    logic        m_iss = 1'b0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic        m_err = 1'b0;
    int          iss_run = 0, iss_max = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        int g;
        logic [N-1:0] ev;
        op_t o;
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_a[i*SZ +: SZ] = ra[i];
            req_b[i*SZ +: SZ] = rb[i];
        end
        @(negedge clk);
        g = -1;
        if (rst_n && arb_en)
            for (int k = 1; k <= N; k++)
                if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        ev = '0;
        if (q.size() > 0 && q[0].due == n) begin
            o = q.pop_front();
            ev = N'(1) << o.id;
            m_data = o.p;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("err", 32'(err), 32'(m_err));
        chk("mul_en_in", 32'(mul_en_in), 32'(m_iss));
        chk("mul_a", 32'(mul_a), 32'(m_a));
        chk("mul_b", 32'(mul_b), 32'(m_b));
        iss_run = mul_en_in ? iss_run + 1 : 0;
        if (iss_run > iss_max) iss_max = iss_run;
        @(posedge clk);
        n++;
        if (spur && rst_n) m_err = 1'b1;
        m_iss = 1'b0;
        m_a = '0;
        m_b = '0;
        if (g >= 0) begin
            m_ptr = g;
            o.id  = g;
            o.p   = 16'(ra[g]) * 16'(rb[g]);
            o.due = n + LAT + 2;
            q.push_back(o);
            grants.push_back(g);
            m_iss = 1'b1;
            m_a = ra[g];
            m_b = rb[g];
            rv[g] = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = N - 1;
        m_data = '0;
        m_iss = 1'b0;
        m_a = '0;
        m_b = '0;
        m_err = 1'b0;
    endtask

    task automatic drain(input int c);
        rv = '0;
        for (int i = 0; i < c; i++) cycle();
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset with all requesters valid: no grant may show.
        ra[0] = 8'd3;   rb[0] = 8'd5;
        ra[1] = 8'd7;   rb[1] = 8'd9;
        ra[2] = 8'd12;  rb[2] = 8'd12;
        ra[3] = 8'd200; rb[3] = 8'd2;
        rv = '1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b1;

        // All four held valid for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            rv = '1;
            cycle();
        end
        drain(LAT + 4);
        chk("rr_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (grants.size() > 0) ? grants.pop_front() : -1;
            chk("rr_order", 32'(g), 32'(i % N));
        end

        // Single request FF*FF.
        ra[0] = 8'hFF; rb[0] = 8'hFF; rv = 4'b0001;
        cycle();
        rv = '0;
        for (int i = 0; i < LAT + 2; i++) cycle();
        chk("ff_data", 32'(rsp_data), 32'hFE01);
        chk("ff_valid", 32'(rsp_valid), 32'b0001);
        drain(3);

        // Six back-to-back from requester 2 alone.
        iss_max = 0;
        for (int i = 0; i < 6; i++) begin
            ra[2] = 8'($urandom); rb[2] = 8'($urandom);
            rv = 4'b0100;
            cycle();
        end
        drain(LAT + 4);
        chk("b2b_run", 32'(iss_max), 32'd6);

        // arb_en drops after two grants.
        grants.delete();
        rv = '1;
        cycle();
        rv = '1;
        cycle();
        arb_en = 1'b0;
        rv = '1;
        for (int i = 0; i < LAT + 6; i++) cycle();
        chk("en_grants", 32'(grants.size()), 32'd2);
        arb_en = 1'b1;
        drain(LAT + 4);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            arb_en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++)
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = 8'($urandom);
                    rb[i] = 8'($urandom);
                end
            cycle();
        end
        arb_en = 1'b1;
        drain(LAT + 4);

        // Reset two cycles after a grant.
        ra[1] = 8'd11; rb[1] = 8'd13; rv = 4'b0010;
        cycle();
        rv = '0;
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        drain(LAT + 6);

        // Spurious result with nothing in flight.
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("err_sticky", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
